// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: opcodes, fetch states, instruction field positions
package cpu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_HALT = 4'b1111;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: instruction memory, issue handshake and decoder feedback
interface fetch_unit_if #(
  parameter int PC_W = 8
);
  import cpu_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [15:0]     imem_rdata;
  opcode_t         op;
  logic [15:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            jump;
  logic            branch;
  logic            zero;
  logic [PC_W-1:0] pc;
  logic            halted;

  modport master (
    output imem_req, imem_addr, op, instr, instr_valid, pc, halted,
    input  imem_valid, imem_rdata, instr_ready, jump, branch, zero
  );

  modport slave (
    input  imem_req, imem_addr, op, instr, instr_valid, pc, halted,
    output imem_valid, imem_rdata, instr_ready, jump, branch, zero
  );

endinterface

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC selector: jump, taken branch or sequential
module pc_next #(
  parameter int PC_W  = 8,
  parameter int IMM_W = 4
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] seq_pc;
  logic            unused_instr;

  assign seq_pc       = pc + PC_W'(1);
  assign unused_instr = ^instr;

  // Sign-extend the low IMM_W bits of the instruction to a PC-wide offset
  always_comb begin
    offset = '0;
    for (int i = 0; i < PC_W; i++) begin
      offset[i] = (i < IMM_W) ? instr[i] : instr[IMM_W-1];
    end
  end

  // Jump beats a taken branch; a branch without zero falls through; all modulo 2^PC_W
  always_comb begin
    next_pc = seq_pc;
    if (jump) begin
      next_pc = instr[PC_W-1:0];
    end else if (branch && zero) begin
      next_pc = seq_pc + offset;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch/issue sequencer; optional HALT opcode support under FETCH_HALT_EN
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_calc;
  logic            accept;
  logic            is_halt;

  assign accept = (state == ISSUE) && bus.instr_ready;

`ifdef FETCH_HALT_EN
  assign is_halt = (opcode_t'(ir[OP_MSB:OP_LSB]) == OP_HALT);
`else
  assign is_halt = 1'b0;
`endif

  pc_next #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W)
  ) u_pc_next (
    .pc      (pc_q),
    .instr   (ir),
    .jump    (bus.jump),
    .branch  (bus.branch),
    .zero    (bus.zero),
    .next_pc (pc_calc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next state: fetch until memory answers, issue until the backend accepts
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (bus.imem_valid) state_nxt = ISSUE;
      ISSUE:   if (bus.instr_ready) state_nxt = is_halt ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Instruction register loads only on the FETCH->ISSUE edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  ir <= '0;
    else if (state == FETCH && bus.imem_valid)  ir <= bus.imem_rdata;
  end

  // PC advances on an accepted issue; a halting instruction leaves it in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  pc_q <= '0;
    else if (accept && !is_halt) pc_q <= pc_calc;
  end

  // Request is gated by reset so it drops the moment reset asserts
  assign bus.imem_req    = (state == FETCH) && !reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state == ISSUE);
  assign bus.instr       = ir;
  assign bus.op          = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign bus.pc          = pc_q;
`ifdef FETCH_HALT_EN
  assign bus.halted      = (state == HALT);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a next-PC reference model
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_pc;

  fetch_unit_if #(.PC_W(8)) bus ();

  fetch_unit #(.PC_W(8), .IMM_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [15:0] w,
                                            input bit j, input bit b, input bit z);
    int imm;
    if (j) return w[7:0];
    imm = int'(w[3:0]);
    if (imm >= 8) imm -= 16;
    if (b && z) return 8'((int'(cur) + 1 + imm + 256) % 256);
    return 8'((int'(cur) + 1) % 256);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF) w[15:12] = 4'h0;
    return w;
  endfunction

  task automatic fetch_one(input int waits, input int stalls, input logic [15:0] word,
                           input bit j, input bit b, input bit z,
                           output int req_cycles, output logic [7:0] addr_seen,
                           output bit on_time, output logic [15:0] got_instr,
                           output logic [3:0] got_op, output bit stable,
                           output logic [7:0] next_addr);
    req_cycles = 0;
    for (int i = 0; i < waits; i++) begin
      if (bus.imem_req === 1'b1 && bus.instr_valid === 1'b0) req_cycles++;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 16'($urandom);
      @(posedge clk); @(negedge clk);
    end
    if (bus.imem_req === 1'b1 && bus.instr_valid === 1'b0) req_cycles++;
    addr_seen = bus.imem_addr;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = word;
    @(posedge clk); @(negedge clk);
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'($urandom);
    on_time = (bus.instr_valid === 1'b1) && (bus.imem_req === 1'b0);
    got_instr = bus.instr;
    got_op = bus.op;
    stable = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      bus.instr_ready = 1'b0;
      bus.jump = 1'($urandom); bus.branch = 1'($urandom); bus.zero = 1'($urandom);
      bus.imem_valid = 1'($urandom);
      bus.imem_rdata = 16'($urandom);
      @(posedge clk); @(negedge clk);
      if (bus.instr !== got_instr || bus.op !== got_op || bus.instr_valid !== 1'b1 ||
          bus.pc !== addr_seen) stable = 1'b0;
    end
    bus.imem_valid = 1'b0;
    bus.instr_ready = 1'b1;
    bus.jump = j; bus.branch = b; bus.zero = z;
    @(posedge clk); @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0; bus.branch = 1'b0; bus.zero = 1'b0;
    next_addr = bus.imem_addr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_ivalid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.pc !== 8'h00 || bus.imem_addr !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h/%h exp=00", bus.pc, bus.imem_addr); end
    checks++; if (bus.instr !== 16'h0000 || bus.op !== 4'h0) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0", bus.instr, bus.op); end
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", bus.imem_req); end
    exp_pc = 8'h00;
  endtask

  task automatic test_sequential();
    int rc; logic [7:0] a, n; bit ot, st; logic [15:0] gi, w; logic [3:0] go;
    for (int k = 0; k < 4; k++) begin
      w = rand_word();
      fetch_one(0, 0, w, 1'b0, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
      checks++; if (a !== 8'(k)) begin failures++; $display("FAIL seq_addr got=%h exp=%h", a, 8'(k)); end
      checks++; if (gi !== w || go !== w[15:12]) begin failures++; $display("FAIL seq_instr got=%h op=%h exp=%h", gi, go, w); end
      checks++; if (rc != 1 || !ot) begin failures++; $display("FAIL seq_timing req_cycles=%0d on_time=%b exp=1/1", rc, ot); end
      exp_pc = model_next(exp_pc, w, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_wait();
    int rc; logic [7:0] a, n; bit ot, st; logic [15:0] gi, w; logic [3:0] go;
    w = rand_word();
    fetch_one(3, 0, w, 1'b0, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    checks++; if (rc != 4) begin failures++; $display("FAIL wait_req_cycles got=%0d exp=4", rc); end
    checks++; if (!ot || gi !== w) begin failures++; $display("FAIL wait_issue on_time=%b instr=%h exp=%h", ot, gi, w); end
    exp_pc = model_next(exp_pc, w, 1'b0, 1'b0, 1'b0);
    checks++; if (n !== exp_pc) begin failures++; $display("FAIL wait_next got=%h exp=%h", n, exp_pc); end
  endtask

  task automatic test_branch();
    int rc; logic [7:0] a, n; bit ot, st; logic [15:0] gi; logic [3:0] go;
    fetch_one(0, 0, 16'h1005, 1'b1, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    checks++; if (n !== 8'h05) begin failures++; $display("FAIL br_setup got=%h exp=05", n); end
    fetch_one(0, 0, 16'h200E, 1'b0, 1'b1, 1'b1, rc, a, ot, gi, go, st, n);
    checks++; if (n !== 8'h04) begin failures++; $display("FAIL br_taken got=%h exp=04", n); end
    fetch_one(1, 0, 16'h1005, 1'b1, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    fetch_one(0, 0, 16'h200E, 1'b0, 1'b1, 1'b0, rc, a, ot, gi, go, st, n);
    checks++; if (n !== 8'h06) begin failures++; $display("FAIL br_not_taken got=%h exp=06", n); end
    fetch_one(0, 0, 16'h3047, 1'b1, 1'b1, 1'b1, rc, a, ot, gi, go, st, n);
    checks++; if (n !== 8'h47) begin failures++; $display("FAIL jump_over_branch got=%h exp=47", n); end
    exp_pc = 8'h47;
  endtask

  task automatic test_jump_wrap();
    int rc; logic [7:0] a, n; bit ot, st; logic [15:0] gi; logic [3:0] go;
    fetch_one(0, 0, 16'h103C, 1'b1, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    checks++; if (n !== 8'h3C) begin failures++; $display("FAIL jump_3c got=%h exp=3c", n); end
    fetch_one(0, 0, 16'h10FF, 1'b1, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    fetch_one(0, 0, 16'h4123, 1'b0, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    checks++; if (a !== 8'hFF || n !== 8'h00) begin failures++; $display("FAIL wrap_up addr=%h next=%h exp=ff/00", a, n); end
    fetch_one(0, 0, 16'h200E, 1'b0, 1'b1, 1'b1, rc, a, ot, gi, go, st, n);
    checks++; if (n !== 8'hFF) begin failures++; $display("FAIL wrap_down got=%h exp=ff", n); end
    exp_pc = 8'hFF;
  endtask

  task automatic test_stall();
    int rc; logic [7:0] a, n; bit ot, st; logic [15:0] gi, w; logic [3:0] go;
    w = rand_word();
    fetch_one(0, 3, w, 1'b0, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    checks++; if (!st) begin failures++; $display("FAIL stall_stable got=0 exp=1"); end
    exp_pc = model_next(exp_pc, w, 1'b0, 1'b0, 1'b0);
    checks++; if (n !== exp_pc) begin failures++; $display("FAIL stall_next got=%h exp=%h", n, exp_pc); end
  endtask

  task automatic test_random();
    int rc, wt; logic [7:0] a, n; bit ot, st, j, b, z; logic [15:0] gi, w; logic [3:0] go;
    for (int k = 0; k < 24; k++) begin
      w = rand_word();
      j = 1'($urandom_range(0, 3) == 0); b = 1'($urandom); z = 1'($urandom);
      wt = $urandom_range(0, 2);
      fetch_one(wt, $urandom_range(0, 2), w, j, b, z, rc, a, ot, gi, go, st, n);
      checks++; if (a !== exp_pc) begin failures++; $display("FAIL rnd_addr k=%0d got=%h exp=%h", k, a, exp_pc); end
      checks++; if (gi !== w || go !== w[15:12] || !st || !ot || rc != wt + 1) begin
        failures++; $display("FAIL rnd_issue k=%0d instr=%h op=%h stable=%b on_time=%b req=%0d exp=%h/%0d", k, gi, go, st, ot, rc, w, wt + 1);
      end
      exp_pc = model_next(exp_pc, w, j, b, z);
      checks++; if (n !== exp_pc) begin failures++; $display("FAIL rnd_next k=%0d got=%h exp=%h", k, n, exp_pc); end
    end
  endtask

  task automatic test_reset_mid();
    int rc; logic [7:0] a, n; bit ot, st; logic [15:0] gi; logic [3:0] go;
    fetch_one(0, 0, 16'h1020, 1'b1, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    bus.imem_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1; #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 8'h00 || bus.imem_addr !== 8'h00) begin
      failures++; $display("FAIL rst_fetch req=%b pc=%h addr=%h exp=0/00/00", bus.imem_req, bus.pc, bus.imem_addr);
    end
    @(negedge clk); reset = 1'b0;
    bus.imem_valid = 1'b1; bus.imem_rdata = 16'h5A5A;
    @(posedge clk); @(negedge clk);
    bus.imem_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1; #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.op !== 4'h0) begin
      failures++; $display("FAIL rst_issue ivalid=%b instr=%h op=%h exp=0/0000/0", bus.instr_valid, bus.instr, bus.op);
    end
    @(negedge clk); reset = 1'b0;
    exp_pc = 8'h00;
  endtask

  task automatic test_halt();
    int rc; logic [7:0] a, n; bit ot, st; logic [15:0] gi, w; logic [3:0] go;
    fetch_one(0, 0, 16'h1033, 1'b1, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    exp_pc = 8'h33;
    w = 16'hF000 | 16'($urandom_range(0, 4095));
    fetch_one(0, 0, w, 1'b0, 1'b0, 1'b0, rc, a, ot, gi, go, st, n);
    checks++; if (!ot || go !== 4'hF) begin failures++; $display("FAIL halt_issue on_time=%b op=%h exp=1/f", ot, go); end
`ifdef FETCH_HALT_EN
    st = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== exp_pc) st = 1'b0;
      bus.imem_valid = 1'($urandom); bus.instr_ready = 1'($urandom);
      @(posedge clk); @(negedge clk);
    end
    checks++; if (!st) begin failures++; $display("FAIL halt_hold halted=%b req=%b pc=%h exp=1/0/%h", bus.halted, bus.imem_req, bus.pc, exp_pc); end
`else
    exp_pc = model_next(exp_pc, w, 1'b0, 1'b0, 1'b0);
    checks++; if (n !== exp_pc || bus.halted !== 1'b0 || bus.imem_req !== 1'b1) begin
      failures++; $display("FAIL halt_plain next=%h halted=%b req=%b exp=%h/0/1", n, bus.halted, bus.imem_req, exp_pc);
    end
`endif
  endtask

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0;
    bus.branch = 1'b0;
    bus.zero = 1'b0;
    exp_pc = 8'h00;
    test_reset();
    test_sequential();
    test_wait();
    test_branch();
    test_jump_wrap();
    test_stall();
    test_random();
    test_reset_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
